// File: rtl/branch_predict_unit.sv
// Branch resolve unit with a direct-mapped IF-stage BTB (2-bit counters).
// Optional statistics counters are built only when BPU_STATS_EN is defined.
module branch_predict_unit #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 4,
    parameter int TAG_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] pc_f,
    output logic              pred_taken_f,
    output logic [DATA_W-1:0] pred_target_f,
    input  logic              ex_valid,
    input  logic [3:0]        br_type,
    input  logic [DATA_W-1:0] br_src0,
    input  logic [DATA_W-1:0] br_src1,
    input  logic [DATA_W-1:0] pc_ex,
    input  logic [DATA_W-1:0] target_ex,
    input  logic              pred_taken_ex,
    input  logic [DATA_W-1:0] pred_target_ex,
    output logic              taken_ex,
    output logic              mispredict,
    output logic [DATA_W-1:0] redirect_pc,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispred
);

    localparam int ENTRIES = 1 << IDX_W;

    localparam logic [3:0] BR_JIRL = 4'd1;
    localparam logic [3:0] BR_B    = 4'd2;
    localparam logic [3:0] BR_BL   = 4'd3;
    localparam logic [3:0] BR_BEQ  = 4'd4;
    localparam logic [3:0] BR_BNE  = 4'd5;
    localparam logic [3:0] BR_BLT  = 4'd6;
    localparam logic [3:0] BR_BGE  = 4'd7;
    localparam logic [3:0] BR_BLTU = 4'd8;
    localparam logic [3:0] BR_BGEU = 4'd9;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [DATA_W-1:0] target_q [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];

    logic [IDX_W-1:0] idx_f;
    logic [TAG_W-1:0] tag_f;
    logic             hit_f;
    logic [IDX_W-1:0] idx_ex;
    logic [TAG_W-1:0] tag_ex;
    logic             hit_ex;
    logic             is_branch;
    logic             cond;
    logic             update;

    // Fetch-side lookup reads the stored table only, so a same-cycle update is not bypassed.
    assign idx_f         = pc_f[IDX_W+1:2];
    assign tag_f         = pc_f[IDX_W+TAG_W+1:IDX_W+2];
    assign hit_f         = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign pred_taken_f  = rst_n && hit_f && ctr_q[idx_f][1];
    assign pred_target_f = pred_taken_f ? target_q[idx_f] : pc_f + DATA_W'(4);

    always_comb begin
        is_branch = 1'b1;
        cond      = 1'b0;
        case (br_type)
            BR_JIRL, BR_B, BR_BL: cond = 1'b1;
            BR_BEQ:  cond = (br_src0 == br_src1);
            BR_BNE:  cond = (br_src0 != br_src1);
            BR_BLT:  cond = ($signed(br_src0) <  $signed(br_src1));
            BR_BGE:  cond = ($signed(br_src0) >= $signed(br_src1));
            BR_BLTU: cond = (br_src0 <  br_src1);
            BR_BGEU: cond = (br_src0 >= br_src1);
            default: is_branch = 1'b0;
        endcase
    end

    // ex_valid qualifies every EX-side output and the table update; no backpressure exists.
    assign update      = ex_valid && is_branch;
    assign taken_ex    = update && cond;
    assign mispredict  = update && ((taken_ex != pred_taken_ex) ||
                                    (taken_ex && (pred_target_ex != target_ex)));
    assign redirect_pc = taken_ex ? target_ex : pc_ex + DATA_W'(4);

    assign idx_ex = pc_ex[IDX_W+1:2];
    assign tag_ex = pc_ex[IDX_W+TAG_W+1:IDX_W+2];
    assign hit_ex = valid_q[idx_ex] && (tag_q[idx_ex] == tag_ex);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (update) begin
            if (hit_ex) begin
                if (cond) begin
                    if (ctr_q[idx_ex] != 2'b11) ctr_q[idx_ex] <= ctr_q[idx_ex] + 2'd1;
                    target_q[idx_ex] <= target_ex;
                end else if (ctr_q[idx_ex] != 2'b00) begin
                    ctr_q[idx_ex] <= ctr_q[idx_ex] - 2'd1;
                end
            end else if (cond) begin
                valid_q[idx_ex]  <= 1'b1;
                tag_q[idx_ex]    <= tag_ex;
                target_q[idx_ex] <= target_ex;
                ctr_q[idx_ex]    <= 2'b10;
            end
        end
    end

`ifdef BPU_STATS_EN
    logic [31:0] branches_q;
    logic [31:0] mispred_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branches_q <= '0;
            mispred_q  <= '0;
        end else begin
            if (update && (branches_q != 32'hFFFF_FFFF)) branches_q <= branches_q + 32'd1;
            if (mispredict && (mispred_q != 32'hFFFF_FFFF)) mispred_q <= mispred_q + 32'd1;
        end
    end

    assign stat_branches = branches_q;
    assign stat_mispred  = mispred_q;
`else
    assign stat_branches = 32'h0;
    assign stat_mispred  = 32'h0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Randomized bench for branch_predict_unit against a table-level reference model.
module tb_branch_predict_unit;

    localparam logic [3:0] T_JIRL = 4'd1, T_B = 4'd2, T_BL = 4'd3, T_BEQ = 4'd4, T_BNE = 4'd5,
                           T_BLT = 4'd6, T_BGE = 4'd7, T_BLTU = 4'd8, T_BGEU = 4'd9;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_f;
    logic        pred_taken_f;
    logic [31:0] pred_target_f;
    logic        ex_valid;
    logic [3:0]  br_type;
    logic [31:0] br_src0, br_src1, pc_ex, target_ex, pred_target_ex;
    logic        pred_taken_ex;
    logic        taken_ex, mispredict;
    logic [31:0] redirect_pc, stat_branches, stat_mispred;

    branch_predict_unit dut (
        .clk(clk), .rst_n(rst_n), .pc_f(pc_f), .pred_taken_f(pred_taken_f),
        .pred_target_f(pred_target_f), .ex_valid(ex_valid), .br_type(br_type),
        .br_src0(br_src0), .br_src1(br_src1), .pc_ex(pc_ex), .target_ex(target_ex),
        .pred_taken_ex(pred_taken_ex), .pred_target_ex(pred_target_ex),
        .taken_ex(taken_ex), .mispredict(mispredict), .redirect_pc(redirect_pc),
        .stat_branches(stat_branches), .stat_mispred(stat_mispred)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: one record per BTB slot, counter kept as an integer 0..3.
    bit          m_valid [16];
    int unsigned m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    longint      m_nb, m_nm;

    function automatic void m_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
        m_nb = 0; m_nm = 0;
    endfunction

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc >> 2) % 16);
    endfunction

    function automatic int unsigned m_tagof(input logic [31:0] pc);
        return int'((pc >> 6) % 256);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
    endfunction

    function automatic bit m_is_br(input logic [3:0] t);
        return (t >= 4'd1) && (t <= 4'd9);
    endfunction

    function automatic bit m_cond(input logic [3:0] t, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = (a >= 32'h8000_0000) ? longint'(a) - 64'sh1_0000_0000 : longint'(a);
        sb = (b >= 32'h8000_0000) ? longint'(b) - 64'sh1_0000_0000 : longint'(b);
        case (t)
            T_JIRL, T_B, T_BL: return 1;
            T_BEQ:  return a == b;
            T_BNE:  return a != b;
            T_BLT:  return sa < sb;
            T_BGE:  return sa >= sb;
            T_BLTU: return longint'(a) < longint'(b);
            T_BGEU: return longint'(a) >= longint'(b);
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] stat_exp(input longint v);
`ifdef BPU_STATS_EN
        return v[31:0];
`else
        return (v == -1) ? 32'h1 : 32'h0;
`endif
    endfunction

    task automatic step(input logic [31:0] pcf, input bit ev, input logic [3:0] t,
                        input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] pcx,
                        input logic [31:0] tgt, input bit pt, input logic [31:0] ptgt);
        bit          e_pt, act, mis, br;
        logic [31:0] e_ptgt;
        int          i;
        @(negedge clk);
        pc_f = pcf; ex_valid = ev; br_type = t; br_src0 = s0; br_src1 = s1;
        pc_ex = pcx; target_ex = tgt; pred_taken_ex = pt; pred_target_ex = ptgt;
        #2;
        e_pt   = m_hit(pcf) && (m_ctr[m_idx(pcf)] >= 2);
        e_ptgt = e_pt ? m_tgt[m_idx(pcf)] : pcf + 32'd4;
        br     = ev && m_is_br(t);
        act    = br && m_cond(t, s0, s1);
        mis    = br && ((act != pt) || (act && ptgt != tgt));
        check("pred_taken_f", {31'd0, pred_taken_f}, {31'd0, e_pt});
        check("pred_target_f", pred_target_f, e_ptgt);
        check("taken_ex", {31'd0, taken_ex}, {31'd0, act});
        check("mispredict", {31'd0, mispredict}, {31'd0, mis});
        exp_q.push_back(act ? tgt : pcx + 32'd4);
        check("redirect_pc", redirect_pc, exp_q.pop_front());
        @(posedge clk);
        if (br) begin
            i = m_idx(pcx);
            if (m_nb < 64'hFFFF_FFFF) m_nb++;
            if (mis && m_nm < 64'hFFFF_FFFF) m_nm++;
            if (m_hit(pcx)) begin
                if (act) begin
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_tgt[i] = tgt;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (act) begin
                m_valid[i] = 1; m_tag[i] = m_tagof(pcx); m_tgt[i] = tgt; m_ctr[i] = 2;
            end
        end
        #1;
        check("stat_branches", stat_branches, stat_exp(m_nb));
        check("stat_mispred", stat_mispred, stat_exp(m_nm));
    endtask

    task automatic mid_cycle_reset(input logic [31:0] pcf);
        @(negedge clk);
        pc_f = pcf; ex_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        m_reset();
        check("rst_pred_taken", {31'd0, pred_taken_f}, 32'd0);
        check("rst_pred_target", pred_target_f, pcf + 32'd4);
        check("rst_stat_branches", stat_branches, 32'd0);
        check("rst_stat_mispred", stat_mispred, 32'd0);
        #1 rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] tg;
        case ($urandom_range(0, 2))
            0: tg = 32'h00;
            1: tg = 32'h01;
            default: tg = 32'hA5;
        endcase
        return 32'h1C00_0000 | (tg << 6) | (32'($urandom_range(0, 15)) << 2);
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 4))
            0: return 32'hFFFF_FFFF;
            1: return 32'h8000_0000;
            default: return 32'($urandom_range(0, 3));
        endcase
    endfunction

    initial begin
        logic [31:0] p, tg, tg2;
        rst_n = 1'b0; pc_f = 32'h1C00_0000; ex_valid = 1'b0; br_type = 4'd0;
        br_src0 = 0; br_src1 = 0; pc_ex = 0; target_ex = 0; pred_taken_ex = 0; pred_target_ex = 0;
        m_reset();
        #3;
        check("reset_pred_taken", {31'd0, pred_taken_f}, 32'd0);
        check("reset_pred_target", pred_target_f, 32'h1C00_0004);
        check("reset_stat_branches", stat_branches, 32'd0);
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Reset lookup, then BEQ allocation and next-cycle hit
        step(32'h1C00_0000, 0, 4'd0, 0, 0, 0, 0, 0, 0);
        step(32'h1C00_0000, 1, T_BEQ, 5, 5, 32'h1C00_0010, 32'h1C00_0040, 0, 0);
        check("beq_redirect_const", redirect_pc, 32'h1C00_0040);
        step(32'h1C00_0010, 0, 4'd0, 0, 0, 0, 0, 0, 0);
        check("beq_btb_target_const", pred_target_f, 32'h1C00_0040);

        // Signed vs unsigned compare on the same operands
        step(32'h1C00_0000, 1, T_BLT, 32'hFFFF_FFFF, 1, 32'h1C00_0080, 32'h1C00_0100, 0, 0);
        step(32'h1C00_0000, 1, T_BLTU, 32'hFFFF_FFFF, 1, 32'h1C00_0084, 32'h1C00_0100, 1, 32'h1C00_0100);
        check("bltu_redirect_const", redirect_pc, 32'h1C00_0088);

        // Counter walk on one entry: 5 taken then 3 not-taken, plus an observing cycle
        for (int k = 0; k < 5; k++)
            step(32'h1C00_0030, 1, T_BEQ, 7, 7, 32'h1C00_0030, 32'h1C00_0300, 0, 0);
        for (int k = 0; k < 3; k++)
            step(32'h1C00_0030, 1, T_BEQ, 7, 8, 32'h1C00_0030, 32'h1C00_0300, 1, 32'h1C00_0300);
        step(32'h1C00_0030, 0, 4'd0, 0, 0, 0, 0, 0, 0);
        check("ctr_walk_final_const", {31'd0, pred_taken_f}, 32'd0);

        // JIRL retarget, then asynchronous reset in the middle of a cycle
        step(32'h1C00_0000, 1, T_JIRL, 0, 0, 32'h1C00_0020, 32'h100, 0, 0);
        step(32'h1C00_0000, 1, T_JIRL, 0, 0, 32'h1C00_0020, 32'h200, 1, 32'h100);
        check("jirl_redirect_const", redirect_pc, 32'h200);
        step(32'h1C00_0020, 0, 4'd0, 0, 0, 0, 0, 0, 0);
        check("jirl_btb_target_const", pred_target_f, 32'h200);
        mid_cycle_reset(32'h1C00_0020);
        step(32'h1C00_0020, 0, 4'd0, 0, 0, 0, 0, 0, 0);

        // Three branches, one mispredict
        step(32'h1C00_0000, 1, T_BEQ, 1, 1, 32'h1C00_0040, 32'h1C00_0400, 1, 32'h1C00_0400);
        step(32'h1C00_0000, 1, T_BNE, 2, 2, 32'h1C00_0044, 32'h1C00_0400, 0, 0);
        step(32'h1C00_0000, 1, T_B, 0, 0, 32'h1C00_0048, 32'h1C00_0500, 0, 0);
        step(32'h1C00_0000, 1, 4'd12, 0, 0, 32'h1C00_004C, 32'h1C00_0500, 1, 32'h1C00_0500);
`ifdef BPU_STATS_EN
        check("stats3_branches_const", stat_branches, 32'd3);
        check("stats3_mispred_const", stat_mispred, 32'd1);
`else
        check("stats3_branches_const", stat_branches, 32'd0);
        check("stats3_mispred_const", stat_mispred, 32'd0);
`endif

        for (int n = 0; n < 500; n++) begin
            p   = rand_pc();
            tg  = rand_pc() + 32'h0010_0000;
            tg2 = ($urandom_range(0, 1) == 1) ? tg : rand_pc();
            step(($urandom_range(0, 2) == 0) ? rand_pc() : p, $urandom_range(0, 5) != 0,
                 4'($urandom_range(0, 11)), rand_op(), rand_op(), p, tg,
                 $urandom_range(0, 1) == 1, tg2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
